alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_pkg.sv | 36 +++
 rtl/alu_pipe_core.sv | 110 +++++++++++
 rtl/alu_pipe.sv | 114 +++++++++++
 tb/tb_alu_pipe.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared op-code constants and types for the alu_pipe block.
// The 6-bit op is {unit[1:0], sub-op[3:0]}; unit picks the functional group.
package alu_pipe_pkg;

  typedef logic [5:0] op_t;

  // Unit select, op[5:4]
  localparam logic [1:0] UNIT_ADD = 2'b00;
  localparam logic [1:0] UNIT_CMP = 2'b01;
  localparam logic [1:0] UNIT_LOG = 2'b10;
  localparam logic [1:0] UNIT_SHF = 2'b11;

  // Compare kinds, op[2:0]
  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_LTS = 3'b010;
  localparam logic [2:0] CMP_LES = 3'b011;
  localparam logic [2:0] CMP_LTU = 3'b100;
  localparam logic [2:0] CMP_LEU = 3'b101;
  localparam logic [2:0] CMP_GTS = 3'b110;
  localparam logic [2:0] CMP_GTU = 3'b111;

  // Logic kinds, op[1:0]
  localparam logic [1:0] LOG_AND = 2'b00;
  localparam logic [1:0] LOG_OR  = 2'b01;
  localparam logic [1:0] LOG_XOR = 2'b10;
  localparam logic [1:0] LOG_NOR = 2'b11;

  // Shift/rotate kinds, op[2:0]; codes above SHF_ROR pass a through
  localparam logic [2:0] SHF_SLL = 3'b000;
  localparam logic [2:0] SHF_SRL = 3'b001;
  localparam logic [2:0] SHF_SRA = 3'b010;
  localparam logic [2:0] SHF_ROL = 3'b011;
  localparam logic [2:0] SHF_ROR = 3'b100;

endpackage

// File: rtl/alu_pipe_core.sv
// alu_core: purely combinational datapath of alu_pipe.
// Optional {N,Z,C,V} flag output is built only when ALU_PIPE_FLAGS_EN is defined.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       op,
  output logic [WIDTH-1:0] result
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam logic [SHW:0] WIDTH_L = WIDTH[SHW:0];

  op_t              op_i;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] add_sum;
`ifdef ALU_PIPE_FLAGS_EN
  logic             add_c;
  logic             add_v;
`endif
  logic [WIDTH:0]   sub_full;
  logic             sub_z;
  logic             sub_v;
  logic             lt_s;
  logic             lt_u;
  logic             cmp_true;
  logic [SHW-1:0]   amt;
  logic [SHW:0]     inv_amt;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] shift_res;

  // Evaluate every unit in parallel, then select by op[5:4]
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    op_i      = op;
    b_eff     = op_i[3] ? ~b : b;
`ifdef ALU_PIPE_FLAGS_EN
    {add_c, add_sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_i[3]};
    add_v     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
`else
    add_sum   = a + b_eff + {{(WIDTH-1){1'b0}}, op_i[3]};
`endif

    // Compares come from a - b: carry means a >= b unsigned, and signed
    // less-than is N xor V so it stays correct when the subtraction overflows.
    sub_full  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    sub_z     = (sub_full[WIDTH-1:0] == '0);
    sub_v     = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
    lt_s      = sub_full[WIDTH-1] ^ sub_v;
    lt_u      = !sub_full[WIDTH];

    cmp_true  = 1'b0;
    case (op_i[2:0])
      CMP_EQ:  cmp_true = sub_z;
      CMP_NE:  cmp_true = !sub_z;
      CMP_LTS: cmp_true = lt_s;
      CMP_LES: cmp_true = lt_s || sub_z;
      CMP_LTU: cmp_true = lt_u;
      CMP_LEU: cmp_true = lt_u || sub_z;
      CMP_GTS: cmp_true = !lt_s && !sub_z;
      CMP_GTU: cmp_true = !lt_u && !sub_z;
      default: cmp_true = 1'b0;
    endcase

    logic_res = '0;
    case (op_i[1:0])
      LOG_AND: logic_res = a & b;
      LOG_OR:  logic_res = a | b;
      LOG_XOR: logic_res = a ^ b;
      LOG_NOR: logic_res = ~(a | b);
      default: logic_res = '0;
    endcase

    // Rotates use a complementary shift by WIDTH-amt; amt=0 shifts by WIDTH, which yields 0.
    amt       = b[SHW-1:0];
    inv_amt   = WIDTH_L - {1'b0, amt};
    shift_res = a;
    case (op_i[2:0])
      SHF_SLL: shift_res = a << amt;
      SHF_SRL: shift_res = a >> amt;
      SHF_SRA: shift_res = $unsigned($signed(a) >>> amt);
      SHF_ROL: shift_res = (a << amt) | (a >> inv_amt);
      SHF_ROR: shift_res = (a >> amt) | (a << inv_amt);
      default: shift_res = a;
    endcase

    result = '0;
    case (op_i[5:4])
      UNIT_ADD: result = add_sum;
      UNIT_CMP: result = {{(WIDTH-1){1'b0}}, cmp_true};
      UNIT_LOG: result = logic_res;
      UNIT_SHF: result = shift_res;
      default:  result = '0;
    endcase

`ifdef ALU_PIPE_FLAGS_EN
    flags = {result[WIDTH-1], (result == '0),
             (op_i[5:4] == UNIT_ADD) && add_c,
             (op_i[5:4] == UNIT_ADD) && add_v};
`endif
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage valid/ready pipeline around alu_core.
// S1 holds the accepted operands, S2 holds the computed result (out).
// Define ALU_PIPE_FLAGS_EN to add the registered flags[3:0] = {N,Z,C,V} output.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  op_t              s1_op_q, s1_op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] core_result;
  logic             s2_load;
  logic             accept;
`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0]       flags_q, flags_d;
  logic [3:0]       core_flags;
`endif

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .op     (s1_op_q),
    .result (core_result)
`ifdef ALU_PIPE_FLAGS_EN
    ,
    .flags  (core_flags)
`endif
  );

  // Handshake and next-state: S2 loads when empty or drained, S1 follows it
  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    in_ready = !rst && (!s1_valid_q || s2_load);
    accept   = in_valid && in_ready && !flush;

    s1_valid_d = s1_valid_q;
    if (s2_load) s1_valid_d = 1'b0;
    if (accept)  s1_valid_d = 1'b1;
    if (flush)   s1_valid_d = 1'b0;

    s1_a_d  = accept ? a  : s1_a_q;
    s1_b_d  = accept ? b  : s1_b_q;
    s1_op_d = accept ? op : s1_op_q;

    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    if (flush) s2_valid_d = 1'b0;

    // out only changes when a real result moves in, so it is stable under stall
    out_d = (s2_load && s1_valid_q) ? core_result : out_q;
`ifdef ALU_PIPE_FLAGS_EN
    flags_d = (s2_load && s1_valid_q) ? core_flags : flags_q;
`endif
  end

  // Control state and the visible result, cleared by synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
`ifdef ALU_PIPE_FLAGS_EN
      flags_q    <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
`ifdef ALU_PIPE_FLAGS_EN
      flags_q    <= flags_d;
`endif
    end
  end

  // S1 operand registers
  always_ff @(posedge clk) begin
    // NOTE: operand data is qualified by s1_valid_q, so it is deliberately left without reset.
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
    s1_op_q <= s1_op_d;
  end

  assign out_valid = s2_valid_q;
  assign out       = out_q;
`ifdef ALU_PIPE_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a 32-bit instance with queued expectations
// popped by a monitor, plus an 8-bit instance driven directly.
module tb_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, out;
  logic [5:0]  op;
`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0]  flags;
`endif

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready), .out(out)
`ifdef ALU_PIPE_FLAGS_EN
    , .flags(flags)
`endif
  );

  // 8-bit instance
  logic       rst8, flush8, in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] a8, b8, out8;
  logic [5:0] op8;
`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0] flags8;
`endif

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8), .out(out8)
`ifdef ALU_PIPE_FLAGS_EN
    , .flags(flags8)
`endif
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   n_acc    = 0;
  int   cyc      = 0;
  logic held_v   = 1'b0;
  logic [31:0] held_out;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every output handshake; verify hold under stall
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) check("out_hold", out, held_out);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("result", out, mon_e.res);
`ifdef ALU_PIPE_FLAGS_EN
          check("flags", flags, mon_e.flg);
`endif
        end
      end
      held_v   = out_valid && !out_ready;
      held_out = out;
    end
  end

  // Offer one op until accepted (bounded); push its expectation on accept
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [5:0] iop,
                       input logic [31:0] er, input logic [3:0] ef);
    bit acc = 1'b0;
    int budget = 0;
    exp_t e;
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        budget++;
        if (budget > 50) begin
          check("accept_timeout", in_ready, 1'b1);
          break;
        end
      end
    end
    if (acc) begin
      e.res = er; e.flg = ef;
      sb.push_back(e);
      n_acc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);
    #1;
  endtask

  task automatic watch_idle(input string name, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check(name, seen, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic seen8;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    rst8 = 1'b1; flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
    a8 = '0; b8 = '0; op8 = '0;

    // Reset behaviour
    @(negedge clk);
    check("in_ready_during_reset", in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("out_valid_reset", out_valid, 1'b0);
    check("out_reset", out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1'b1);
    @(posedge clk); #1;

    // Two-cycle latency, overflow into sign bit
    issue(32'h7FFFFFFF, 32'h1, 6'b000000, 32'h80000000, 4'b1001);
    @(negedge clk);
    check("latency_cycle1_no_valid", out_valid, 1'b0);
    @(negedge clk);
    check("latency_cycle2_valid", out_valid, 1'b1);
    @(posedge clk); #1;

    // Directed vectors: {a, b, op, result, {N,Z,C,V}}
    issue(32'hFFFFFFFF, 32'h1,        6'b010000, 32'h0,        4'b0100);
    issue(32'hFFFFFFFF, 32'h1,        6'b010010, 32'h1,        4'b0000);
    issue(32'hFFFFFFFF, 32'h1,        6'b010100, 32'h0,        4'b0100);
    issue(32'h80000001, 32'h21,       6'b110010, 32'hC0000000, 4'b1000);
    issue(32'h80000001, 32'h21,       6'b110100, 32'hC0000000, 4'b1000);
    issue(32'h80000001, 32'h21,       6'b110011, 32'h00000003, 4'b0000);
    issue(32'h5,        32'h7,        6'b001000, 32'hFFFFFFFE, 4'b1000);
    issue(32'h7,        32'h5,        6'b001000, 32'h2,        4'b0010);
    issue(32'h80000000, 32'h1,        6'b001000, 32'h7FFFFFFF, 4'b0011);
    issue(32'hFFFFFFFF, 32'h1,        6'b000000, 32'h0,        4'b0110);
    issue(32'h80000000, 32'h1,        6'b010010, 32'h1,        4'b0000);
    issue(32'h7FFFFFFF, 32'h80000000, 6'b010110, 32'h1,        4'b0000);
    issue(32'h80000000, 32'h1,        6'b010011, 32'h1,        4'b0000);
    issue(32'h5,        32'h5,        6'b010101, 32'h1,        4'b0000);
    issue(32'h5,        32'h5,        6'b010001, 32'h0,        4'b0100);
    issue(32'h80000000, 32'h1,        6'b010111, 32'h1,        4'b0000);
    issue(32'hF0F0F0F0, 32'hFF00FF00, 6'b100000, 32'hF000F000, 4'b1000);
    issue(32'hF0F0F0F0, 32'hFF00FF00, 6'b100001, 32'hFFF0FFF0, 4'b1000);
    issue(32'hF0F0F0F0, 32'hFF00FF00, 6'b100010, 32'h0FF00FF0, 4'b0000);
    issue(32'hF0F0F0F0, 32'hFF00FF00, 6'b100011, 32'h000F000F, 4'b0000);
    issue(32'h1,        32'h1F,       6'b110000, 32'h80000000, 4'b1000);
    issue(32'h80000000, 32'hFFFFFFE4, 6'b110001, 32'h08000000, 4'b0000);
    issue(32'hF0000000, 32'h4,        6'b110010, 32'hFF000000, 4'b1000);
    issue(32'h12345678, 32'h0,        6'b110100, 32'h12345678, 4'b0000);
    issue(32'h12345678, 32'h0,        6'b110101, 32'h12345678, 4'b0000);
    issue(32'h1,        32'h20,       6'b110000, 32'h1,        4'b0000);
    drain();

    // Full throughput: six ops in six cycles with out_ready high
    c0 = cyc;
    issue(32'h1, 32'h2, 6'b000000, 32'h3, 4'b0000);
    issue(32'h3, 32'h4, 6'b000000, 32'h7, 4'b0000);
    issue(32'h9, 32'h1, 6'b001000, 32'h8, 4'b0010);
    issue(32'hA, 32'h5, 6'b100010, 32'hF, 4'b0000);
    issue(32'h2, 32'h3, 6'b110000, 32'h10, 4'b0000);
    issue(32'h6, 32'h6, 6'b010000, 32'h1, 4'b0000);
    check("throughput_cycles", cyc - c0, 6);
    drain();

    // Back-pressure: out_ready low for four cycles while five ops stream in
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        issue(32'h1,  32'h1,  6'b000000, 32'h2,  4'b0000);
        issue(32'h2,  32'h2,  6'b000000, 32'h4,  4'b0000);
        issue(32'h3,  32'h3,  6'b000000, 32'h6,  4'b0000);
        issue(32'h4,  32'h4,  6'b000000, 32'h8,  4'b0000);
        issue(32'h10, 32'h20, 6'b000000, 32'h30, 4'b0000);
      end
      begin
        repeat (3) @(negedge clk);
        check("in_ready_low_when_full", in_ready, 1'b0);
        check("accepts_before_stall", n_acc, 2);
        check("stalled_out_first_result", out, 32'h2);
        @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with pipe full and an op offered: everything discarded
    out_ready = 1'b0;
    issue(32'h11, 32'h1, 6'b000000, 32'h12, 4'b0000);
    issue(32'h22, 32'h1, 6'b000000, 32'h23, 4'b0000);
    flush = 1'b1;
    a = 32'h33; b = 32'h1; op = 6'b000000; in_valid = 1'b1;
    @(negedge clk);
    check("pipe_full_before_flush", out_valid, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_clears_out_valid", out_valid, 1'b0);
    check("in_ready_after_flush", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    watch_idle("no_output_after_flush_full", 6);

    // Flush while in_ready is high: the offered op must not be accepted
    issue(32'h44, 32'h1, 6'b000000, 32'h45, 4'b0000);
    flush = 1'b1;
    a = 32'h55; b = 32'h1; op = 6'b000000; in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_in_flush_cycle", in_ready, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    watch_idle("no_output_after_flush_partial", 5);
    issue(32'h66, 32'h1, 6'b001000, 32'h65, 4'b0010);
    drain();

    // 8-bit instance: nor giving zero
    a8 = 8'h0F; b8 = 8'hF0; op8 = 6'b100011; in_valid8 = 1'b1;
    @(negedge clk);
    check("w8_in_ready", in_ready8, 1'b1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    check("w8_latency_cycle1", out_valid8, 1'b0);
    @(negedge clk);
    check("w8_out_valid", out_valid8, 1'b1);
    check("w8_nor_result", out8, 8'h00);
`ifdef ALU_PIPE_FLAGS_EN
    check("w8_nor_flags", flags8, 4'b0100);
`endif
    @(posedge clk); #1;

    // 8-bit instance: reset in the middle of a stalled stream
    out_ready8 = 1'b0;
    a8 = 8'h01; b8 = 8'h02; op8 = 6'b000000; in_valid8 = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("w8_pre_reset_valid", out_valid8, 1'b1);
    check("w8_pre_reset_out", out8, 8'h03);
    @(posedge clk); #1;
    rst8 = 1'b1;
    @(negedge clk);
    check("w8_in_ready_in_reset", in_ready8, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("w8_reset_out_valid", out_valid8, 1'b0);
    check("w8_reset_out", out8, 8'h00);
    @(posedge clk); #1;
    rst8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(negedge clk);
    check("w8_in_ready_after_reset", in_ready8, 1'b1);
    seen8 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen8 = seen8 | out_valid8;
    end
    check("w8_in_flight_discarded", seen8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
